// File: rtl/execute_pipe_if.sv
// Handshake and operand/result bundle between decode, the execute stage and memory.
// The master side drives operations and consumes results; the slave side is the execute stage.
interface execute_pipe_if #(
  parameter int XLEN = 64
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      icode_i;
  logic [3:0]      ifun_i;
  logic [XLEN-1:0] valA_i;
  logic [XLEN-1:0] valB_i;
  logic [XLEN-1:0] valC_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] valE_o;
  logic            Cnd_o;
  logic            err_o;
  logic [2:0]      cc_o;

  modport master (
    output in_valid_i, icode_i, ifun_i, valA_i, valB_i, valC_i, out_ready_i,
    input  in_ready_o, out_valid_o, valE_o, Cnd_o, err_o, cc_o
  );

  modport slave (
    input  in_valid_i, icode_i, ifun_i, valA_i, valB_i, valC_i, out_ready_i,
    output in_ready_o, out_valid_o, valE_o, Cnd_o, err_o, cc_o
  );
endinterface

// File: rtl/execute_pipe.sv
// Registered Y86-64 execute stage: valE, branch/cmov condition and the ZF/SF/OF register,
// with valid/ready flow control and an iterative shift-add multiplier for FMULL.
module execute_pipe #(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  execute_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] WBYTES = XLEN'(XLEN / 8);

  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MUL} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   valE_q, valE_d;
  logic              cnd_q, cnd_d, err_q, err_d, ovld_q, ovld_d;
  logic [2:0]        cc_q, cc_d;
  logic [XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Returns {legal, taken} for a jXX/cmov condition against {ZF,SF,OF}.
  function automatic logic [1:0] cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (fn)
      4'd0:    return 2'b11;
      4'd1:    return {1'b1, (sf ^ of) | zf};
      4'd2:    return {1'b1, sf ^ of};
      4'd3:    return {1'b1, zf};
      4'd4:    return {1'b1, !zf};
      4'd5:    return {1'b1, !(sf ^ of)};
      4'd6:    return {1'b1, !(sf ^ of) && !zf};
      default: return 2'b00;
    endcase
  endfunction

  logic signed [XLEN-1:0] opa_s, opb_s, alu_s;
  logic [XLEN-1:0]        res_valE, mul_sum;
  logic                   res_cnd, res_err, res_ccwr, res_mul, of_b;
  logic [2:0]             res_cc;
  logic [1:0]             cond;
  logic                   in_rdy, accept, consume;

  always_comb begin
    opa_s    = bus.valA_i;
    opb_s    = bus.valB_i;
    alu_s    = '0;
    of_b     = 1'b0;
    res_valE = '0;
    res_cnd  = 1'b0;
    res_err  = 1'b0;
    res_ccwr = 1'b0;
    res_mul  = 1'b0;
    cond     = cond_eval(bus.ifun_i, cc_q);
    case (bus.icode_i)
      IHALT, INOP: ;
      IRRMOVQ: begin
        res_valE = cond[1] ? bus.valA_i : '0;
        res_cnd  = cond[0];
        res_err  = !cond[1];
      end
      IJXX: begin
        res_cnd = cond[0];
        res_err = !cond[1];
      end
      IIRMOVQ:          res_valE = bus.valC_i;
      IRMMOVQ, IMRMOVQ: res_valE = bus.valB_i + bus.valC_i;
      ICALL, IPUSHQ:    res_valE = bus.valB_i - WBYTES;
      IRET, IPOPQ:      res_valE = bus.valB_i + WBYTES;
      IOPQ: begin
        res_ccwr = 1'b1;
        case (bus.ifun_i)
          4'd0: begin
            alu_s = opb_s + opa_s;
            of_b  = (opa_s[XLEN-1] == opb_s[XLEN-1]) && (alu_s[XLEN-1] != opa_s[XLEN-1]);
          end
          4'd1: begin
            alu_s = opb_s - opa_s;
            of_b  = (opa_s[XLEN-1] != opb_s[XLEN-1]) && (alu_s[XLEN-1] != opb_s[XLEN-1]);
          end
          4'd2: alu_s = opb_s & opa_s;
          4'd3: alu_s = opb_s ^ opa_s;
          4'd4: begin
            res_ccwr = 1'b0;
            res_mul  = MUL_EN;
            res_err  = !MUL_EN;
          end
          default: begin
            res_ccwr = 1'b0;
            res_err  = 1'b1;
          end
        endcase
        res_valE = alu_s;
      end
      default: res_err = 1'b1;
    endcase
    res_cc = {alu_s == '0, alu_s[XLEN-1], of_b};
  end

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign in_rdy  = (state_q != S_MUL) && (!ovld_q || bus.out_ready_i);
  assign accept  = bus.in_valid_i && in_rdy;
  assign consume = ovld_q && bus.out_ready_i;

  always_comb begin
    state_d  = state_q;
    valE_d   = valE_q;
    cnd_d    = cnd_q;
    err_d    = err_q;
    cc_d     = cc_q;
    ovld_d   = ovld_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = S_HOLD;
          ovld_d  = 1'b1;
          valE_d  = mul_sum;
          cnd_d   = 1'b0;
          err_d   = 1'b0;
          cc_d    = {mul_sum == '0, mul_sum[XLEN-1], 1'b0};
        end
      end
      default: begin
        if (consume) begin
          state_d = S_IDLE;
          ovld_d  = 1'b0;
        end
        // A new acceptance overrides the consume, so back-to-back results leave no bubble.
        if (accept) begin
          if (res_mul) begin
            state_d  = S_MUL;
            ovld_d   = 1'b0;
            acc_d    = '0;
            mcand_d  = bus.valB_i;
            mplier_d = bus.valA_i;
            cnt_d    = '0;
          end else begin
            state_d = S_HOLD;
            ovld_d  = 1'b1;
            valE_d  = res_valE;
            cnd_d   = res_cnd;
            err_d   = res_err;
            if (res_ccwr) cc_d = res_cc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      valE_q  <= '0;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      cc_q    <= 3'b100;
      ovld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valE_q  <= valE_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
      cc_q    <= cc_d;
      ovld_q  <= ovld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiplier working registers are only meaningful in S_MUL, so they carry no reset.
  always_ff @(posedge clk_i) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_valid_o = ovld_q;
  assign bus.valE_o      = valE_q;
  assign bus.Cnd_o       = cnd_q;
  assign bus.err_o       = err_q;
  assign bus.cc_o        = cc_q;
endmodule
